// File: rtl/irq_dispatch_ctrl.sv
// Interrupt entry/exit sequencer: freezes the pipeline, saves the return PC, vectors to the ISR and restores on RETI.
// Optional nesting is enabled by defining IRQ_NEST_EN; otherwise a single return register is used.
module irq_dispatch_ctrl #(
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] VECTOR_BASE = PC_WIDTH'(16'h0040),
  parameter int                  NEST_DEPTH  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                irq_req,
  input  logic [4:0]          irq_num,
  input  logic                pipe_drained,
  input  logic [PC_WIDTH-1:0] current_pc,
  input  logic                reti,
  output logic                stall_req,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_target,
  output logic                irq_ack,
  output logic [4:0]          ack_num,
  output logic                in_service,
  output logic [2:0]          nest_level,
  output logic                stack_overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STALL    = 2'd1,
    DISPATCH = 2'd2,
    RETURN   = 2'd3
  } stateT;

  if ((NEST_DEPTH < 1) || (NEST_DEPTH > 7)) begin : gDepthCheck
    $error("irq_dispatch_ctrl: NEST_DEPTH must be in 1..7");
  end

  stateT               stateQ;
  logic [2:0]          levelQ;
  logic [4:0]          numQ;
  logic [PC_WIDTH-1:0] stackTop;
  logic [PC_WIDTH-1:0] vecAddr;
  logic                pushEn;

  assign pushEn  = (stateQ == STALL) && pipe_drained;
  assign vecAddr = VECTOR_BASE + PC_WIDTH'({numQ, 2'b00});

`ifdef IRQ_NEST_EN
  localparam logic [2:0] LIMIT = 3'(NEST_DEPTH);
  localparam int         IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stackMem [2**IDX_W];
  logic [IDX_W-1:0]    pushIdx;
  logic [IDX_W-1:0]    popIdx;
  logic                ovfSet;
  logic                ovfQ;

  // Level never exceeds the depth, so modular index arithmetic stays in range.
  assign pushIdx  = levelQ[IDX_W-1:0];
  assign popIdx   = pushIdx - IDX_W'(1);
  assign stackTop = stackMem[popIdx];
  assign ovfSet   = (stateQ == IDLE) && !(reti && (levelQ != 3'd0)) && irq_req && (levelQ == LIMIT);

  // Return-address stack storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        stackMem[i] <= '0;
      end
    end else if (pushEn) begin
      stackMem[pushIdx] <= current_pc;
    end
  end

  // Sticky record of a request refused because the stack was full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovfQ <= 1'b0;
    end else if (ovfSet) begin
      ovfQ <= 1'b1;
    end
  end

  assign stack_overflow = ovfQ;
`else
  localparam logic [2:0] LIMIT = 3'd1;

  logic [PC_WIDTH-1:0] stackReg;

  assign stackTop = stackReg;

  // Single return-address register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stackReg <= '0;
    end else if (pushEn) begin
      stackReg <= current_pc;
    end
  end

  assign stack_overflow = 1'b0;
`endif

  // Sequencing FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ    <= IDLE;
      levelQ    <= 3'd0;
      numQ      <= 5'd0;
      stall_req <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      irq_ack   <= 1'b0;
      ack_num   <= 5'd0;
    end else begin
      pc_load   <= 1'b0;
      pc_target <= '0;
      irq_ack   <= 1'b0;
      ack_num   <= 5'd0;
      case (stateQ)
        IDLE: begin
          // RETI wins over a simultaneous request; that request is dropped.
          if (reti && (levelQ != 3'd0)) begin
            stateQ    <= RETURN;
            stall_req <= 1'b0;
            pc_load   <= 1'b1;
            pc_target <= stackTop;
            levelQ    <= levelQ - 3'd1;
          end else if (irq_req && (levelQ < LIMIT)) begin
            stateQ    <= STALL;
            stall_req <= 1'b1;
            numQ      <= irq_num;
          end else begin
            stateQ    <= IDLE;
            stall_req <= 1'b0;
          end
        end
        STALL: begin
          if (pipe_drained) begin
            stateQ    <= DISPATCH;
            stall_req <= 1'b1;
            pc_load   <= 1'b1;
            pc_target <= vecAddr;
            irq_ack   <= 1'b1;
            ack_num   <= numQ;
            levelQ    <= levelQ + 3'd1;
          end else begin
            stateQ    <= STALL;
            stall_req <= 1'b1;
          end
        end
        DISPATCH: begin
          stateQ    <= IDLE;
          stall_req <= 1'b0;
        end
        RETURN: begin
          stateQ    <= IDLE;
          stall_req <= 1'b0;
        end
        default: begin
          stateQ    <= IDLE;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

  assign nest_level = levelQ;
  assign in_service = (levelQ != 3'd0);

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Scoreboard bench for irq_dispatch_ctrl: stimulus queues expected PC loads, a negedge monitor checks them.
module tb_irq_dispatch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        irq_req = 1'b0;
  logic [4:0]  irq_num = 5'd0;
  logic        pipe_drained = 1'b0;
  logic [15:0] current_pc = 16'h0000;
  logic        reti = 1'b0;
  logic        stall_req;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        irq_ack;
  logic [4:0]  ack_num;
  logic        in_service;
  logic [2:0]  nest_level;
  logic        stack_overflow;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [15:0] target;
    logic        ack;
    logic [4:0]  num;
    logic [2:0]  level;
    logic        stall;
  } expT;

  expT expQ[$];

  irq_dispatch_ctrl #(
    .PC_WIDTH   (16),
    .VECTOR_BASE(16'h0040),
    .NEST_DEPTH (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .irq_req       (irq_req),
    .irq_num       (irq_num),
    .pipe_drained  (pipe_drained),
    .current_pc    (current_pc),
    .reti          (reti),
    .stall_req     (stall_req),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .irq_ack       (irq_ack),
    .ack_num       (ack_num),
    .in_service    (in_service),
    .nest_level    (nest_level),
    .stack_overflow(stack_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_stall_req"}, 32'(stall_req), 32'd0);
    check({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    check({tag, "_pc_target"}, 32'(pc_target), 32'd0);
    check({tag, "_irq_ack"}, 32'(irq_ack), 32'd0);
    check({tag, "_ack_num"}, 32'(ack_num), 32'd0);
    check({tag, "_in_service"}, 32'(in_service), 32'd0);
    check({tag, "_nest_level"}, 32'(nest_level), 32'd0);
    check({tag, "_stack_overflow"}, 32'(stack_overflow), 32'd0);
  endtask

  task automatic expectLoad(input logic [15:0] tgt, input logic ack, input logic [4:0] num,
                            input logic [2:0] lvl, input logic stl);
    expT e;
    e.target = tgt;
    e.ack    = ack;
    e.num    = num;
    e.level  = lvl;
    e.stall  = stl;
    expQ.push_back(e);
  endtask

  task automatic dispatchIrq(input logic [4:0] num, input logic [15:0] pc,
                             input logic [15:0] expTarget, input logic [2:0] expLevel);
    current_pc = pc;
    irq_num    = num;
    irq_req    = 1'b1;
    expectLoad(expTarget, 1'b1, num, expLevel, 1'b1);
    tick();
    irq_req = 1'b0;
    irq_num = 5'd0;
    check("stall_after_req", 32'(stall_req), 32'd1);
    tick();
    tick();
    pipe_drained = 1'b1;
    tick();
    pipe_drained = 1'b0;
    tick();
    check("stall_released", 32'(stall_req), 32'd0);
  endtask

  task automatic doReti(input logic [15:0] expTarget, input logic [2:0] expLevel);
    expectLoad(expTarget, 1'b0, 5'd0, expLevel, 1'b0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
  endtask

  // Monitor: every PC load or ack must match the oldest queued expectation.
  initial begin
    expT e;
    forever begin
      @(negedge clock);
      if (pc_load || irq_ack) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("FAIL unexpected_output: pc_load=%0b irq_ack=%0b pc_target=%0h ack_num=%0d, expected no output",
                   pc_load, irq_ack, pc_target, ack_num);
        end else begin
          e = expQ.pop_front();
          check("mon_pc_load", 32'(pc_load), 32'd1);
          check("mon_pc_target", 32'(pc_target), 32'(e.target));
          check("mon_irq_ack", 32'(irq_ack), 32'(e.ack));
          check("mon_ack_num", 32'(ack_num), 32'(e.num));
          check("mon_nest_level", 32'(nest_level), 32'(e.level));
          check("mon_in_service", 32'(in_service), 32'(e.level != 3'd0));
          check("mon_stall_req", 32'(stall_req), 32'(e.stall));
        end
      end
    end
  end

  initial begin
    #2;
    checkAllZero("reset");
    #20;
    reset = 1'b1;
    tick();

    // Vector 3 -> 0x004C, then return to 0x0123.
    dispatchIrq(5'd3, 16'h0123, 16'h004C, 3'd1);
    check("t1_nest_level", 32'(nest_level), 32'd1);
    check("t1_in_service", 32'(in_service), 32'd1);
    doReti(16'h0123, 3'd0);
    check("t2_in_service", 32'(in_service), 32'd0);

    // RETI at level 0 must do nothing.
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    check("reti_lvl0_stall", 32'(stall_req), 32'd0);
    check("reti_lvl0_level", 32'(nest_level), 32'd0);

    // RETI and a request in the same cycle: return wins, request dropped.
    dispatchIrq(5'd7, 16'h0456, 16'h005C, 3'd1);
    expectLoad(16'h0456, 1'b0, 5'd0, 3'd0, 1'b0);
    reti    = 1'b1;
    irq_req = 1'b1;
    irq_num = 5'd5;
    tick();
    reti    = 1'b0;
    irq_req = 1'b0;
    irq_num = 5'd0;
    check("t3_no_stall_a", 32'(stall_req), 32'd0);
    tick();
    check("t3_no_stall_b", 32'(stall_req), 32'd0);
    tick();
    check("t3_level", 32'(nest_level), 32'd0);

    // Highest vector number.
    dispatchIrq(5'd31, 16'hBEEF, 16'h00BC, 3'd1);
    doReti(16'hBEEF, 3'd0);

`ifdef IRQ_NEST_EN
    dispatchIrq(5'd1, 16'h0100, 16'h0044, 3'd1);
    dispatchIrq(5'd2, 16'h0200, 16'h0048, 3'd2);
    current_pc = 16'h0300;
    irq_num    = 5'd3;
    irq_req    = 1'b1;
    tick();
    irq_req = 1'b0;
    check("t4_refused_stall", 32'(stall_req), 32'd0);
    check("t4_overflow", 32'(stack_overflow), 32'd1);
    check("t4_level", 32'(nest_level), 32'd2);
    pipe_drained = 1'b1;
    tick();
    tick();
    pipe_drained = 1'b0;
    check("t4_no_dispatch", 32'(stall_req), 32'd0);
    doReti(16'h0200, 3'd1);
    doReti(16'h0100, 3'd0);
    check("t4_overflow_sticky", 32'(stack_overflow), 32'd1);
`else
    dispatchIrq(5'd2, 16'h0777, 16'h0048, 3'd1);
    irq_num      = 5'd9;
    irq_req      = 1'b1;
    pipe_drained = 1'b1;
    tick();
    irq_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_stall", 32'(stall_req), 32'd0);
      tick();
    end
    pipe_drained = 1'b0;
    check("t5_overflow", 32'(stack_overflow), 32'd0);
    check("t5_level", 32'(nest_level), 32'd1);
    doReti(16'h0777, 3'd0);
`endif

    // Reset while stalled, pipeline not drained.
    current_pc = 16'h0999;
    irq_num    = 5'd4;
    irq_req    = 1'b1;
    tick();
    irq_req = 1'b0;
    check("t6_stalled", 32'(stall_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("t6_midreset");
    @(negedge clock);
    #1;
    reset = 1'b1;
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("t6_reti_no_load", 32'(pc_load), 32'd0);
    tick();
    tick();
    check("t6_idle_stall", 32'(stall_req), 32'd0);

    repeat (3) tick();
    while (expQ.size() != 0) begin
      expT e;
      e = expQ.pop_front();
      assertCount++;
      failCount++;
      $display("FAIL missing_output: pc_target %0h never loaded, expected within test window", e.target);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
